fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Parametrised, time-multiplexed FIR filter: one signed multiply-accumulate per clock over a runtime tap count
//  (1..MAX_TAPS), with a writable coefficient bank, a circular sample delay line and valid/ready streaming I/O.
//  Sits between a sample source and a downstream consumer in the filter datapath; replaces a fixed 8-bit microcoded FIR.
// PARAMETERS
//  DATA_W    8   sample width, signed two's complement
//  COEF_W    8   coefficient width, signed two's complement
//  MAX_TAPS  16  delay-line/coefficient depth; power of 2, >=2
//  TAP_W     $clog2(MAX_TAPS)+1  width of num_taps (derived, do not override)
//  OUT_W     DATA_W+COEF_W+$clog2(MAX_TAPS)  result width (derived; no overflow possible)
// PORTS
//  clk           in   1        rising-edge clock
//  reset_n       in   1        asynchronous, active-low reset
//  coef_wr_en    in   1        write coef_wr_data to coefficient coef_wr_addr (IDLE only)
//  coef_wr_addr  in   clog2(MAX_TAPS)  coefficient index k (h[k] multiplies x[n-k])
//  coef_wr_data  in   COEF_W   coefficient value
//  num_taps      in   TAP_W    tap count, sampled on input handshake
//  flush         in   1        clear sample history (IDLE only)
//  in_valid      in   1        sample offered
//  in_ready      out  1        block can accept a sample
//  in_data       in   DATA_W   sample x[n]
//  out_valid     out  1        result available
//  out_ready     in   1        consumer takes result
//  out_data      out  OUT_W    y[n] = sum_{k=0}^{T-1} h[k]*x[n-k], signed
//  busy          out  1        high in MAC or OUT state
//  cfg_err       out  1        one-cycle pulse: num_taps out of range at handshake
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, cfg_err=0,
//   all coefficients=0, wr_ptr=0, fill=0. Sample RAM contents need not be cleared (masked by fill).
//  States: IDLE -> MAC -> OUT -> IDLE.
//  IDLE: in_ready=1. in_valid&&in_ready at edge E0: x[n] written at wr_ptr, wr_ptr+=1 (wraps mod MAX_TAPS),
//   fill=min(fill+1,MAX_TAPS), T latched from num_taps, acc=0, k=0, go MAC.
//  num_taps==0 or >MAX_TAPS: T=MAX_TAPS, cfg_err=1 for the cycle after E0.
//  MAC: one term per cycle, k=0..T-1; term=h[k]*x[n-k] if k<fill else 0 (history past flush/reset reads as zero).
//   Products full-precision signed DATA_W+COEF_W, sign-extended into OUT_W accumulator. After term T-1, go OUT.
//  OUT: out_data=acc, out_valid=1; held stable until out_ready. On out_valid&&out_ready -> IDLE, out_valid=0
//   next cycle. out_data holds last result afterwards.
//  Latency: out_valid rises exactly T+1 clocks after E0. Max throughput 1 sample per T+2 clocks (out_ready=1).
//  in_ready=0 in MAC/OUT; no input skid buffering. in_valid need not be held after a rejected attempt.
//  coef_wr_en: effective only in IDLE; ignored (no write) in MAC/OUT. Write in IDLE coincident with an input
//   handshake applies before the MAC pass for that sample.
//  flush in IDLE: fill=0, wr_ptr=0. flush coincident with handshake: flush first, then sample written
//   (fill becomes 1). flush outside IDLE ignored.
//  Async reset mid-MAC/OUT: pending result discarded, out_valid drops immediately, all state as reset.
//  Coefficient bank and num_taps changes never corrupt a pass in progress.
// TESTING
//  1 Impulse: h={1,2,3,4}, T=4, inputs 1,0,0,0,0 -> outputs 1,2,3,4,0; out_valid 5 clocks after each E0.
//  2 Extremes: DATA_W=COEF_W=8, T=16, all h=-128, all x=-128 -> y after 16 samples = 262144 (fits OUT_W=20),
//    first output = 16384 (fill masking).
//  3 Backpressure: out_ready low 10 cycles in OUT -> out_valid/out_data stable, in_ready=0, in_valid ignored.
//  4 Flush: h={1,1,1,1}, inputs 5,5,flush+5 -> third output 5, not 15; coef write during MAC ignored.
//  5 Range: num_taps=0 and 17 -> cfg_err one-cycle pulse, T=16 used; num_taps=1 -> y=h[0]*x[n], latency 2.
//  6 Reset: reset_n low in MAC cycle 3 -> out_valid=0 immediately; next sample computes with fill=1, h=0 -> 0.

Source files
------------

// File: rtl/fir_mac_seq_if.sv
// Streaming and configuration bundle for fir_mac_seq: coefficient write port,
// sample input handshake, result output handshake and status flags.
interface fir_mac_seq_if #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int MAX_TAPS = 16
);
    localparam int ADDR_W = $clog2(MAX_TAPS);
    localparam int TAP_W  = $clog2(MAX_TAPS) + 1;
    localparam int OUT_W  = DATA_W + COEF_W + $clog2(MAX_TAPS);

    logic                     coef_wr_en;
    logic [ADDR_W-1:0]        coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic [TAP_W-1:0]         num_taps;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;
    logic                     cfg_err;

    modport slave (
        input  coef_wr_en, coef_wr_addr, coef_wr_data, num_taps, flush,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, cfg_err
    );

    modport master (
        output coef_wr_en, coef_wr_addr, coef_wr_data, num_taps, flush,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, cfg_err
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one signed MAC per clock over a runtime tap count, with a
// writable coefficient bank, circular sample history and valid/ready streaming I/O.
module fir_mac_seq #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int MAX_TAPS = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    fir_mac_seq_if.slave   bus
);
    localparam int ADDR_W = $clog2(MAX_TAPS);
    localparam int TAP_W  = $clog2(MAX_TAPS) + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int OUT_W  = DATA_W + COEF_W + $clog2(MAX_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [TAP_W-1:0]         fill_q, fill_d;
    logic [TAP_W-1:0]         taps_q, taps_d;
    logic [TAP_W-1:0]         k_q, k_d;
    logic signed [OUT_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     cfg_err_q, cfg_err_d;
    logic signed [COEF_W-1:0] coef_rd_q, coef_rd_d;
    logic                     term_vld_q, term_vld_d;

    logic signed [COEF_W-1:0] coef_q [MAX_TAPS];
    logic signed [DATA_W-1:0] samp_mem [MAX_TAPS];
    logic signed [DATA_W-1:0] samp_rd_q;

    logic                     is_idle;
    logic                     hs;
    logic                     flush_eff;
    logic                     coef_we;
    logic                     taps_bad;
    logic                     issue;
    logic [ADDR_W-1:0]        wr_base;
    logic [TAP_W-1:0]         fill_base;
    logic [ADDR_W-1:0]        rd_idx;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  term;
    logic signed [OUT_W-1:0]  acc_sum;

    assign is_idle   = (state_q == ST_IDLE);
    assign hs        = is_idle && bus.in_valid;
    assign flush_eff = is_idle && bus.flush;
    assign coef_we   = is_idle && bus.coef_wr_en;
    assign taps_bad  = (bus.num_taps == '0) || (bus.num_taps > TAP_W'(MAX_TAPS));

    // A flush coincident with a handshake takes effect first, so the new sample lands at slot 0.
    assign wr_base   = flush_eff ? '0 : wr_ptr_q;
    assign fill_base = flush_eff ? '0 : fill_q;

    // Newest sample sits one slot behind wr_ptr; x[n-k] walks backwards around the ring.
    assign rd_idx  = wr_ptr_q - ADDR_W'(1) - k_q[ADDR_W-1:0];
    assign issue   = (state_q == ST_MAC) && (k_q < taps_q);

    assign prod    = PROD_W'(samp_rd_q) * PROD_W'(coef_rd_q);
    assign term    = term_vld_q ? OUT_W'(prod) : '0;
    assign acc_sum = acc_q + term;

    assign term_vld_d = issue && (k_q < fill_q);
    assign coef_rd_d  = coef_q[k_q[ADDR_W-1:0]];

    // Sample history: plain RAM with registered read, never reset (stale slots are masked by fill).
    always_ff @(posedge clk) begin
        if (hs) begin
            samp_mem[wr_base] <= bus.in_data;
        end
        samp_rd_q <= samp_mem[rd_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we) begin
            coef_q[bus.coef_wr_addr] <= bus.coef_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            taps_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
            coef_rd_q  <= '0;
            term_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            taps_q     <= taps_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            cfg_err_q  <= cfg_err_d;
            coef_rd_q  <= coef_rd_d;
            term_vld_q <= term_vld_d;
        end
    end

    // The read pipeline adds one cycle: k runs 0..T-1 issuing reads, k==T drains the last term.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        taps_d     = taps_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ptr_d = wr_base;
                fill_d   = fill_base;
                if (bus.in_valid) begin
                    wr_ptr_d  = wr_base + ADDR_W'(1);
                    fill_d    = (fill_base == TAP_W'(MAX_TAPS)) ? fill_base
                                                                : fill_base + TAP_W'(1);
                    taps_d    = taps_bad ? TAP_W'(MAX_TAPS) : bus.num_taps;
                    cfg_err_d = taps_bad;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                if (k_q < taps_q) begin
                    k_d = k_q + TAP_W'(1);
                end else begin
                    out_data_d = acc_sum;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = is_idle;
    assign bus.busy      = !is_idle;
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: directed scenarios plus random traffic, all checked every
// cycle against a sum-of-products model of the filter and its handshake timing.
module tb_fir_mac_seq;
    localparam int DATA_W   = 8;
    localparam int COEF_W   = 8;
    localparam int MAX_TAPS = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fir_mac_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS)) bus ();

    fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 60) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int  h [MAX_TAPS];
    int  hist [$];
    bit  m_idle = 1'b1;
    bit  m_out  = 1'b0;
    bit  m_cfg  = 1'b0;
    int  m_wait = 0;
    int  pend_y = 0;
    int  last_y = 0;

    always @(negedge clk) begin
        int t;
        int s;
        int nk;
        bit nc;
        if (!reset_n) begin
            for (int i = 0; i < MAX_TAPS; i++) h[i] = 0;
            hist.delete();
            m_idle = 1'b1;
            m_out  = 1'b0;
            m_cfg  = 1'b0;
            m_wait = 0;
            last_y = 0;
        end
        chk("in_ready",  bus.in_ready,  m_idle);
        chk("busy",      bus.busy,      !m_idle);
        chk("out_valid", bus.out_valid, m_out);
        chk("out_data",  $signed(bus.out_data), last_y);
        chk("cfg_err",   bus.cfg_err,   m_cfg);
        if (reset_n) begin
            nc = 1'b0;
            if (m_idle) begin
                if (bus.coef_wr_en) h[bus.coef_wr_addr] = int'(bus.coef_wr_data);
                if (bus.flush) hist.delete();
                if (bus.in_valid) begin
                    hist.push_front(int'(bus.in_data));
                    if (hist.size() > MAX_TAPS) void'(hist.pop_back());
                    t  = int'(bus.num_taps);
                    nc = (t == 0) || (t > MAX_TAPS);
                    if (nc) t = MAX_TAPS;
                    nk = (t < hist.size()) ? t : hist.size();
                    s  = 0;
                    for (int k = 0; k < nk; k++) s += h[k] * hist[k];
                    pend_y = s;
                    m_idle = 1'b0;
                    m_wait = t + 1;
                end
            end else if (!m_out) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_out  = 1'b1;
                    last_y = pend_y;
                end
            end else if (bus.out_ready) begin
                m_out  = 1'b0;
                m_idle = 1'b1;
            end
            m_cfg = nc;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int a, input int d);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 4'(a);
        bus.coef_wr_data = 8'(d);
        step();
        bus.coef_wr_en   = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic accept(input int x, input int nt, input bit fl, input bit mcw, output bit cfg);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(x);
        bus.num_taps = 5'(nt);
        bus.flush    = fl;
        step();
        acc_cyc      = cyc;
        cfg          = bus.cfg_err;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        if (mcw) begin
            bus.coef_wr_en   = 1'b1;
            bus.coef_wr_addr = 4'($urandom_range(0, 3));
            bus.coef_wr_data = 8'($urandom_range(1, 127));
            step();
            bus.coef_wr_en   = 1'b0;
        end
    endtask

    task automatic collect(input bit bp, output int y, output int lat);
        int n;
        bit got;
        n = 0; got = 1'b0; y = 0; lat = -1;
        if (bp) bus.out_ready = 1'($urandom_range(0, 1));
        while (n < 200) begin
            step();
            n++;
            if (bus.out_valid) begin
                if (!got) begin
                    got = 1'b1;
                    y   = int'($signed(bus.out_data));
                    lat = cyc - acc_cyc;
                end
                bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.out_ready) begin
                    step();
                    break;
                end
            end
        end
        if (!got) chk("collect_timeout", 0, 1);
        bus.out_ready = 1'b1;
        $display("txn y=%0d latency=%0d", y, lat);
    endtask

    task automatic send(input int x, input int nt, input bit fl, input bit mcw,
                        output int y, output int lat, output bit cfg);
        accept(x, nt, fl, mcw, cfg);
        collect(1'b0, y, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  y, lat, d0, n;
        bit  cfg;
        int  imp_in [5]  = '{1, 0, 0, 0, 0};
        int  imp_out [5] = '{1, 2, 3, 4, 0};

        bus.coef_wr_en = 0; bus.coef_wr_addr = 0; bus.coef_wr_data = 0;
        bus.num_taps = 5'd4; bus.flush = 0; bus.in_valid = 0; bus.in_data = 0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("reset_out_data", $signed(bus.out_data), 0);
        reset_n = 1'b1;
        step();

        // Impulse response
        for (int i = 0; i < 4; i++) wr_coef(i, i + 1);
        for (int i = 0; i < 5; i++) begin
            send(imp_in[i], 4, 1'b0, 1'b0, y, lat, cfg);
            chk("impulse_y", y, imp_out[i]);
            chk("impulse_lat", lat, 5);
        end

        // Tap-count range
        send(7, 1, 1'b0, 1'b0, y, lat, cfg);
        chk("t1_y", y, 7);
        chk("t1_lat", lat, 2);
        chk("t1_cfg", cfg, 0);
        send(1, 0, 1'b0, 1'b0, y, lat, cfg);
        chk("t0_cfg", cfg, 1);
        chk("t0_lat", lat, 17);
        send(1, 17, 1'b0, 1'b0, y, lat, cfg);
        chk("t17_cfg", cfg, 1);
        chk("t17_lat", lat, 17);

        // Flush and ignored coefficient write during MAC
        for (int i = 0; i < 4; i++) wr_coef(i, 1);
        do_flush();
        send(5, 4, 1'b0, 1'b0, y, lat, cfg);
        chk("flush_y0", y, 5);
        send(5, 4, 1'b0, 1'b1, y, lat, cfg);
        chk("flush_y1", y, 10);
        send(5, 4, 1'b1, 1'b0, y, lat, cfg);
        chk("flush_y2", y, 5);

        // Backpressure
        bus.out_ready = 1'b0;
        accept(3, 4, 1'b0, 1'b0, cfg);
        n = 0;
        while (!bus.out_valid && n < 50) begin step(); n++; end
        chk("bp_valid", bus.out_valid, 1);
        d0 = int'($signed(bus.out_data));
        chk("bp_y", d0, 8);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            step();
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_data", $signed(bus.out_data), d0);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", bus.out_valid, 0);

        // Extremes
        for (int i = 0; i < MAX_TAPS; i++) wr_coef(i, -128);
        do_flush();
        for (int i = 0; i < MAX_TAPS; i++) begin
            send(-128, 16, 1'b0, 1'b0, y, lat, cfg);
            if (i == 0) chk("ext_first", y, 16384);
            if (i == MAX_TAPS - 1) chk("ext_full", y, 262144);
        end

        // Reset in MAC cycle 3
        accept(9, 16, 1'b0, 1'b0, cfg);
        step(); step();
        reset_n = 1'b0;
        #1;
        chk("rst_mac_valid", bus.out_valid, 0);
        chk("rst_mac_ready", bus.in_ready, 1);
        step(); step();
        reset_n = 1'b1;
        step();
        send(9, 4, 1'b0, 1'b0, y, lat, cfg);
        chk("rst_y", y, 0);

        // Reset while a result is held in OUT
        wr_coef(0, 1);
        bus.out_ready = 1'b0;
        accept(2, 1, 1'b0, 1'b0, cfg);
        n = 0;
        while (!bus.out_valid && n < 50) begin step(); n++; end
        chk("rst_out_pre", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_out_drop", bus.out_valid, 0);
        chk("rst_out_data", $signed(bus.out_data), 0);
        bus.out_ready = 1'b1;
        step(); step();
        reset_n = 1'b1;
        step();

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) wr_coef($urandom_range(0, MAX_TAPS - 1), $urandom);
            accept($urandom, $urandom_range(0, 18), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), cfg);
            collect(1'b1, y, lat);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
